// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I integer execute stage.
// Decodes opcode / funct3 / funct7[5] into a 4-bit ALU operation, computes the
// result combinationally and keeps a registered copy for the next stage.
// Optional build macro: ALU_EXEC_FLAGS_EN adds registered zero/neg flags.
module alu_exec_unit #(
    parameter int XLEN = 32  // only 32 is supported
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct,
    input  logic            add_rshift_type,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            stall,
    output logic [3:0]      ALUop,
    output logic [XLEN-1:0] Out,
    output logic [XLEN-1:0] OutReg
`ifdef ALU_EXEC_FLAGS_EN
    ,
    output logic            zero,
    output logic            neg
`endif
);

    // ALU operation codes (11-14 unused, treated like INVALID)
    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_AND     = 4'd2;
    localparam logic [3:0] ALU_OR      = 4'd3;
    localparam logic [3:0] ALU_XOR     = 4'd4;
    localparam logic [3:0] ALU_SLT     = 4'd5;
    localparam logic [3:0] ALU_SLTU    = 4'd6;
    localparam logic [3:0] ALU_SLL     = 4'd7;
    localparam logic [3:0] ALU_SRA     = 4'd8;
    localparam logic [3:0] ALU_SRL     = 4'd9;
    localparam logic [3:0] ALU_COPY_B  = 4'd10;
    localparam logic [3:0] ALU_INVALID = 4'd15;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    logic [4:0] shamt;
    logic       lt_signed;
    logic       lt_unsigned;

    // Instruction decode into ALU operation code
    always_comb begin
        ALUop = ALU_INVALID;
        case (opcode)
            OPC_LUI: ALUop = ALU_COPY_B;
            OPC_AUIPC, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_JAL, OPC_JALR: ALUop = ALU_ADD;
            OPC_OP, OPC_OP_IMM: begin
                case (funct)
                    // bit 30 only means SUB for register-register ops;
                    // in an immediate it is just part of the constant
                    3'b000:  ALUop = (add_rshift_type && (opcode == OPC_OP)) ? ALU_SUB : ALU_ADD;
                    3'b001:  ALUop = ALU_SLL;
                    3'b010:  ALUop = ALU_SLT;
                    3'b011:  ALUop = ALU_SLTU;
                    3'b100:  ALUop = ALU_XOR;
                    3'b101:  ALUop = add_rshift_type ? ALU_SRA : ALU_SRL;
                    3'b110:  ALUop = ALU_OR;
                    default: ALUop = ALU_AND;
                endcase
            end
            default: ALUop = ALU_INVALID;
        endcase
    end

    assign shamt       = B[4:0];
    assign lt_signed   = $signed(A) < $signed(B);
    assign lt_unsigned = A < B;

    // Combinational datapath selected by the decoded operation
    always_comb begin
        Out = '0;
        case (ALUop)
            ALU_ADD:    Out = A + B;
            ALU_SUB:    Out = A - B;
            ALU_AND:    Out = A & B;
            ALU_OR:     Out = A | B;
            ALU_XOR:    Out = A ^ B;
            ALU_SLT:    Out = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU:   Out = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_SLL:    Out = A << shamt;
            ALU_SRA:    Out = $unsigned($signed(A) >>> shamt);
            ALU_SRL:    Out = A >> shamt;
            ALU_COPY_B: Out = B;
            default:    Out = '0;
        endcase
    end

    // Pipeline register: captures the result unless stalled
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            OutReg <= '0;
        end else if (!stall) begin
            OutReg <= Out;
        end
    end

`ifdef ALU_EXEC_FLAGS_EN
    // Result flags, captured alongside OutReg
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            zero <= 1'b0;
            neg  <= 1'b0;
        end else if (!stall) begin
            zero <= (Out == '0);
            neg  <= Out[XLEN-1];
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (scoreboard queues for comb and registered paths).
module tb_alu_exec_unit;

    logic        Clock;
    logic        Reset;
    logic [6:0]  opcode;
    logic [2:0]  funct;
    logic        add_rshift_type;
    logic [31:0] A;
    logic [31:0] B;
    logic        stall;
    logic [3:0]  ALUop;
    logic [31:0] Out;
    logic [31:0] OutReg;
`ifdef ALU_EXEC_FLAGS_EN
    logic        zero;
    logic        neg;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  aluop;
        logic [31:0] out;
    } exp_t;

    exp_t        comb_q[$];
    logic [31:0] reg_q[$];

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        b30;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  e_op;
        logic [31:0] e_out;
    } vec_t;

    alu_exec_unit #(.XLEN(32)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .opcode(opcode),
        .funct(funct),
        .add_rshift_type(add_rshift_type),
        .A(A),
        .B(B),
        .stall(stall),
        .ALUop(ALUop),
        .Out(Out),
        .OutReg(OutReg)
`ifdef ALU_EXEC_FLAGS_EN
        ,
        .zero(zero),
        .neg(neg)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model written from the instruction set description
    function automatic logic [3:0] model_op(input logic [6:0] op, input logic [2:0] f3, input logic b30);
        if (op == 7'b0110111) return 4'd10;
        if (op == 7'b0010111 || op == 7'b1100011 || op == 7'b0000011 ||
            op == 7'b0100011 || op == 7'b1101111 || op == 7'b1100111) return 4'd0;
        if (op != 7'b0110011 && op != 7'b0010011) return 4'd15;
        if (f3 == 3'b000) return (op == 7'b0110011 && b30) ? 4'd1 : 4'd0;
        if (f3 == 3'b001) return 4'd7;
        if (f3 == 3'b010) return 4'd5;
        if (f3 == 3'b011) return 4'd6;
        if (f3 == 3'b100) return 4'd4;
        if (f3 == 3'b101) return b30 ? 4'd8 : 4'd9;
        if (f3 == 3'b110) return 4'd3;
        return 4'd2;
    endfunction

    function automatic logic [31:0] model_out(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        int          sh;
        sh = int'(b[4:0]);
        case (code)
            4'd0:  return a + b;
            4'd1:  return a + ~b + 32'd1;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ((a[31] & ~b[31]) | ((a[31] == b[31]) & (a < b))) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << sh;
            4'd8: begin
                ext = {{32{a[31]}}, a} >> sh;
                return ext[31:0];
            end
            4'd9:  return a >> sh;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic b30,
                         input logic [31:0] a, input logic [31:0] b);
        opcode          = op;
        funct           = f3;
        add_rshift_type = b30;
        A               = a;
        B               = b;
    endtask

    task automatic test_reset();
        logic [31:0] exp_r;
        Reset = 1'b1;
        stall = 1'b0;
        drive(7'b0110111, 3'd0, 1'b0, 32'd0, 32'hA5A5_0001);
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if (OutReg !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold OutReg=%h expected=%h", OutReg, 32'd0);
        end
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        exp_r = 32'hA5A5_0001;
        checks++;
        if (OutReg !== exp_r) begin
            errors++;
            $display("FAIL first_capture OutReg=%h expected=%h", OutReg, exp_r);
        end
        // Async reset between edges: clock is idle for the next 4 time units
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        checks++;
        if (OutReg !== 32'd0) begin
            errors++;
            $display("FAIL async_reset OutReg=%h expected=%h", OutReg, 32'd0);
        end
        #1;
        Reset = 1'b0;
    endtask

    task automatic test_decode();
        vec_t v[$];
        exp_t e;
        v.push_back('{7'b0110111, 3'($urandom_range(7)), 1'($urandom_range(1)), 32'h1234_5678, 32'hFFFF8123, 4'd10, 32'hFFFF8123});
        v.push_back('{7'b0110011, 3'b000, 1'b0, 32'h80000005, 32'hFFFF8003, 4'd0, 32'h7FFF8008});
        v.push_back('{7'b0110011, 3'b000, 1'b1, 32'h80000005, 32'hFFFF8003, 4'd1, 32'h80008002});
        v.push_back('{7'b0010011, 3'b000, 1'b1, 32'h80000005, 32'hFFFF8003, 4'd0, 32'h7FFF8008});
        v.push_back('{7'b0110011, 3'b010, 1'b0, 32'hFFFFFFFF, 32'h00000001, 4'd5, 32'h00000001});
        v.push_back('{7'b0110011, 3'b011, 1'b0, 32'hFFFFFFFF, 32'h00000001, 4'd6, 32'h00000000});
        v.push_back('{7'b0110011, 3'b101, 1'b1, 32'h80000000, 32'h00000024, 4'd8, 32'hF8000000});
        v.push_back('{7'b0110011, 3'b101, 1'b0, 32'h80000000, 32'h00000024, 4'd9, 32'h08000000});
        v.push_back('{7'b0010011, 3'b101, 1'b1, 32'h80000000, 32'h00000024, 4'd8, 32'hF8000000});
        v.push_back('{7'b0110011, 3'b001, 1'b0, 32'h00000001, 32'hFFFFFFE1, 4'd7, 32'h00000002});
        v.push_back('{7'b0110011, 3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd4, 32'h0FF00FF0});
        v.push_back('{7'b0110011, 3'b110, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd3, 32'hFFF0FFF0});
        v.push_back('{7'b0110011, 3'b111, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd2, 32'hF000F000});
        v.push_back('{7'b0010011, 3'b011, 1'b1, 32'h00000000, 32'h00000001, 4'd6, 32'h00000001});
        v.push_back('{7'b0010111, 3'b111, 1'b1, 32'h00001000, 32'h00000234, 4'd0, 32'h00001234});
        v.push_back('{7'b1100011, 3'b001, 1'b1, 32'hFFFFFFFF, 32'h00000002, 4'd0, 32'h00000001});
        v.push_back('{7'b0000011, 3'b010, 1'b0, 32'h00000100, 32'hFFFFFFFC, 4'd0, 32'h000000FC});
        v.push_back('{7'b0100011, 3'b101, 1'b1, 32'h00000010, 32'h00000008, 4'd0, 32'h00000018});
        v.push_back('{7'b1101111, 3'b000, 1'b1, 32'h00000004, 32'h00000004, 4'd0, 32'h00000008});
        v.push_back('{7'b1100111, 3'b110, 1'b0, 32'h00000003, 32'h00000005, 4'd0, 32'h00000008});
        v.push_back('{7'b1111111, 3'b000, 1'b0, 32'h12345678, 32'h9ABCDEF0, 4'd15, 32'h00000000});
        v.push_back('{7'b0000000, 3'b000, 1'b0, 32'h12345678, 32'h9ABCDEF0, 4'd15, 32'h00000000});
        foreach (v[i]) begin
            @(negedge Clock);
            drive(v[i].op, v[i].f3, v[i].b30, v[i].a, v[i].b);
            comb_q.push_back('{v[i].e_op, v[i].e_out});
            #1;
            e = comb_q.pop_front();
            checks++;
            if (ALUop !== e.aluop || Out !== e.out) begin
                errors++;
                $display("FAIL decode_vec%0d op=%b f3=%b b30=%b ALUop=%0d Out=%h expected ALUop=%0d Out=%h",
                         i, v[i].op, v[i].f3, v[i].b30, ALUop, Out, e.aluop, e.out);
            end
        end
    endtask

    task automatic test_random_ops();
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        b30;
        logic [31:0] a, b;
        logic [3:0]  code;
        exp_t        e;
        for (int i = 0; i < 60; i++) begin
            op  = ($urandom_range(1) == 0) ? 7'b0110011 : 7'b0010011;
            f3  = 3'($urandom_range(7));
            b30 = 1'($urandom_range(1));
            a   = $urandom;
            b   = $urandom;
            code = model_op(op, f3, b30);
            @(negedge Clock);
            drive(op, f3, b30, a, b);
            comb_q.push_back('{code, model_out(code, a, b)});
            #1;
            e = comb_q.pop_front();
            checks++;
            if (ALUop !== e.aluop || Out !== e.out) begin
                errors++;
                $display("FAIL random_op%0d op=%b f3=%b b30=%b A=%h B=%h ALUop=%0d Out=%h expected ALUop=%0d Out=%h",
                         i, op, f3, b30, a, b, ALUop, Out, e.aluop, e.out);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        logic [31:0] a, b;
        @(negedge Clock);
        stall = 1'b0;
        a = 32'h0000_1111;
        b = 32'h0000_2222;
        drive(7'b0110011, 3'b000, 1'b0, a, b);
        held = model_out(4'd0, a, b);
        @(posedge Clock);
        #1;
        checks++;
        if (OutReg !== held) begin
            errors++;
            $display("FAIL stall_preload OutReg=%h expected=%h", OutReg, held);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            stall = 1'b1;
            drive(7'b0110111, 3'd0, 1'b0, 32'd0, $urandom);
            @(posedge Clock);
            #1;
            checks++;
            if (OutReg !== held) begin
                errors++;
                $display("FAIL stall_hold%0d OutReg=%h expected=%h", i, OutReg, held);
            end
        end
        @(negedge Clock);
        stall = 1'b0;
        drive(7'b0110011, 3'b000, 1'b1, 32'd100, 32'd300);
        reg_q.push_back(32'hFFFF_FF38);
        @(posedge Clock);
        #1;
        held = reg_q.pop_front();
        checks++;
        if (OutReg !== held) begin
            errors++;
            $display("FAIL stall_release OutReg=%h expected=%h", OutReg, held);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        b30;
        logic [31:0] a, b, e;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            stall = 1'b0;
            op  = ($urandom_range(1) == 0) ? 7'b0110011 : 7'b0110111;
            f3  = 3'($urandom_range(7));
            b30 = 1'($urandom_range(1));
            a   = $urandom;
            b   = $urandom;
            drive(op, f3, b30, a, b);
            reg_q.push_back(model_out(model_op(op, f3, b30), a, b));
            @(posedge Clock);
            #1;
            e = reg_q.pop_front();
            checks++;
            if (OutReg !== e) begin
                errors++;
                $display("FAIL back_to_back%0d OutReg=%h expected=%h", i, OutReg, e);
            end
        end
    endtask

    task automatic test_reset_over_stall();
        @(negedge Clock);
        stall = 1'b1;
        Reset = 1'b1;
        #1;
        checks++;
        if (OutReg !== 32'd0) begin
            errors++;
            $display("FAIL reset_over_stall OutReg=%h expected=%h", OutReg, 32'd0);
        end
        @(negedge Clock);
        Reset = 1'b0;
        drive(7'b0110111, 3'd0, 1'b0, 32'd0, 32'hCAFE_F00D);
        @(posedge Clock);
        #1;
        checks++;
        if (OutReg !== 32'd0) begin
            errors++;
            $display("FAIL release_stalled OutReg=%h expected=%h", OutReg, 32'd0);
        end
        @(negedge Clock);
        stall = 1'b0;
        @(posedge Clock);
        #1;
        checks++;
        if (OutReg !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL release_capture OutReg=%h expected=%h", OutReg, 32'hCAFE_F00D);
        end
    endtask

`ifdef ALU_EXEC_FLAGS_EN
    task automatic test_flags();
        @(negedge Clock);
        stall = 1'b0;
        drive(7'b0110011, 3'b000, 1'b1, 32'h1357_9BDF, 32'h1357_9BDF);
        @(posedge Clock);
        #1;
        checks++;
        if (zero !== 1'b1 || neg !== 1'b0) begin
            errors++;
            $display("FAIL flags_equal_sub zero=%b neg=%b expected zero=1 neg=0", zero, neg);
        end
        @(negedge Clock);
        drive(7'b0110011, 3'b000, 1'b1, 32'd1, 32'd2);
        @(posedge Clock);
        #1;
        checks++;
        if (zero !== 1'b0 || neg !== 1'b1) begin
            errors++;
            $display("FAIL flags_negative zero=%b neg=%b expected zero=0 neg=1", zero, neg);
        end
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        checks++;
        if (zero !== 1'b0 || neg !== 1'b0) begin
            errors++;
            $display("FAIL flags_reset zero=%b neg=%b expected zero=0 neg=0", zero, neg);
        end
        Reset = 1'b0;
    endtask
`endif

    initial begin
        Reset = 1'b1;
        stall = 1'b0;
        drive(7'd0, 3'd0, 1'b0, 32'd0, 32'd0);
        test_reset();
        test_decode();
        test_random_ops();
        test_stall();
        test_back_to_back();
        test_reset_over_stall();
`ifdef ALU_EXEC_FLAGS_EN
        test_flags();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Integer execute stage for the RV32I pipeline.
- Merges the opcode/funct decoder and the 32-bit ALU into one block.
- Decodes opcode, funct3 and funct7[5] into a 4-bit ALU operation, then computes the result combinationally.
- Also holds a registered copy of the result for the next pipeline stage.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- Clock  in  1  pipeline clock; rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- opcode  in  7  instruction bits [6:0].
- funct  in  3  instruction funct3.
- add_rshift_type  in  1  instruction bit 30 (funct7[5]).
- A  in  32  operand A (rs1 or PC).
- B  in  32  operand B (rs2 or immediate).
- stall  in  1  when high, the registered result holds.
- ALUop  out  4  decoded operation code.
- Out  out  32  combinational result.
- OutReg  out  32  registered result.

Behaviour:
ALUop encoding:
- 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR.
- 5 SLT (signed); 6 SLTU (unsigned).
- 7 SLL; 8 SRA; 9 SRL.
- 10 COPY_B.
- 15 INVALID; codes 11-14 are unused.

Decode (combinational):
- LUI 0110111 -> COPY_B.
- AUIPC 0010111, BRANCH 1100011, LOAD 0000011, STORE 0100011, JAL 1101111, JALR 1100111 -> ADD. funct and add_rshift_type are ignored for these opcodes.
- R-type 0110011, by funct3:
  - 000 -> ADD if add_rshift_type=0, SUB if 1.
  - 001 SLL; 010 SLT; 011 SLTU; 100 XOR.
  - 101 -> SRL if add_rshift_type=0, SRA if 1.
  - 110 OR; 111 AND.
- I-type 0010011: same mapping as R-type, except funct3 000 is always ADD regardless of add_rshift_type. For funct3 101, add_rshift_type still selects SRA vs SRL.
- Any other opcode -> INVALID.

Datapath (combinational):
- ADD/SUB wrap modulo 2^32; no overflow flag.
- SLT/SLTU: Out = 32'd1 if A<B, else 0. SLT compares two's complement; SLTU compares unsigned.
- Shift amount is B[4:0] only; B[31:5] are ignored.
- SRA replicates A[31]; SRL and SLL fill with zeros.
- COPY_B: Out = B.
- INVALID or unused codes: Out = 0.
- Out settles within the same cycle as input changes; no latency.

Register:
- OutReg <= Out on each rising Clock edge when stall=0; it holds when stall=1.
- Reset asserted: OutReg = 0 immediately, without waiting for a clock edge.
- Reset dominates stall. Reset released mid-operation: the first capture happens on the next edge with stall=0.
- ALUop and Out do not depend on Reset.

Optional Feature:
- Macro: ALU_EXEC_FLAGS_EN.
- Defined: adds two outputs.
  - zero (1 bit): registered; set to 1 when the captured result is all zeros.
  - neg (1 bit): registered copy of the captured result bit 31.
  - Both are updated under the same stall and Reset rules as OutReg; reset value is 0.
- Undefined: these ports and their flops are absent. All other behaviour is identical.

Test Plan:
- LUI, funct random, add_rshift_type random, B=32'hFFFF8123 -> ALUop=10, Out=32'hFFFF8123.
- R-type funct 000, A=32'h80000005, B=32'hFFFF8003:
  - add_rshift_type=0 -> Out=32'h7FFF8008.
  - add_rshift_type=1 -> Out=32'h80008002.
- I-type funct 000 with add_rshift_type=1 -> ADD, not SUB.
- Compares and shifts:
  - SLT with A=32'hFFFFFFFF, B=1 -> Out=1; SLTU with the same operands -> Out=0.
  - SRA with A=32'h80000000, B=32'h00000024 (shift 4) -> Out=32'hF8000000.
  - SRL with the same operands -> Out=32'h08000000.
- Opcode 1111111 -> ALUop=15, Out=0.
- Registered path:
  - Reset high with Clock idle -> OutReg=0 immediately.
  - stall=1 across 3 edges -> OutReg holds.
  - stall=0 -> OutReg equals the prior cycle's Out.
  - With ALU_EXEC_FLAGS_EN: SUB of equal operands -> zero=1, neg=0 after the edge.
